// File: rtl/entry_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// entry_alloc_ctrl
//
// Tracks ENTRIES slots with a valid bitmap and hands out free slots using
// round-robin order. For each slot it also produces a one-cycle write-enable
// pulse. A pulse is raised when the slot is allocated or when an already-valid
// slot is rewritten.
//
// Ports
//   clk        : single clock, all state updates on posedge
//   rst_n      : asynchronous active-low reset
//   alloc_vld  : request to allocate one entry
//   alloc_rdy  : an entry is available (== !full), combinational
//   alloc_id   : index granted this cycle, combinational, valid while alloc_rdy
//   upd_vld    : request to rewrite an already-valid entry
//   upd_id     : entry targeted by upd_vld
//   free_vld   : request to release one entry
//   free_id    : entry released by free_vld
//   ff_en_e1   : registered per-entry write-enable pulse (one cycle latency)
//   entry_vld  : registered valid bitmap
//   count      : registered number of valid entries
//   full/empty : combinational, count==ENTRIES / count==0
//   err        : sticky protocol-error flag, cleared only by reset
// -----------------------------------------------------------------------------
module entry_alloc_ctrl #(
    parameter int ENTRIES = 8,
    parameter int IDW     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_vld,
    output logic               alloc_rdy,
    output logic [IDW-1:0]     alloc_id,
    input  logic               upd_vld,
    input  logic [IDW-1:0]     upd_id,
    input  logic               free_vld,
    input  logic [IDW-1:0]     free_id,
    output logic [ENTRIES-1:0] ff_en_e1,
    output logic [ENTRIES-1:0] entry_vld,
    output logic [IDW:0]       count,
    output logic               full,
    output logic               empty,
    output logic               err
);

    logic [IDW-1:0]     rr_ptr;
    logic               alloc_acc;
    logic               upd_in_rng;
    logic               free_in_rng;
    logic               upd_acc;
    logic               free_acc;
    logic               upd_bad;
    logic               free_bad;
    logic [ENTRIES-1:0] alloc_oh;
    logic [ENTRIES-1:0] upd_oh;
    logic [ENTRIES-1:0] free_oh;
    logic [IDW-1:0]     rr_nxt;
    logic [IDW:0]       srch_idx;

    assign full      = (count == (IDW+1)'(ENTRIES));
    assign empty     = (count == '0);
    assign alloc_rdy = !full;

    // Round-robin search starting at rr_ptr. The loop walks from the farthest
    // candidate back to the nearest one, so the nearest free slot is the last
    // one written and therefore wins. srch_idx is one bit wider than an index.
    // That width holds rr_ptr+k (at most 2*ENTRIES-2) before the wrap is
    // subtracted.
    always_comb begin
        alloc_id = '0;
        srch_idx = '0;
        for (int k = ENTRIES-1; k >= 0; k--) begin
            srch_idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (srch_idx >= (IDW+1)'(ENTRIES))
                srch_idx = srch_idx - (IDW+1)'(ENTRIES);
            if (!entry_vld[srch_idx[IDW-1:0]])
                alloc_id = srch_idx[IDW-1:0];
        end
    end

    // Request acceptance. Every request is judged against the registered
    // state only. As a result, a slot freed this cycle cannot be granted
    // until the next cycle. An alloc always targets an invalid slot and a
    // free always targets a valid one, so their one-hots never overlap.
    assign alloc_acc   = alloc_vld && alloc_rdy;
    assign upd_in_rng  = ({1'b0, upd_id}  < (IDW+1)'(ENTRIES));
    assign free_in_rng = ({1'b0, free_id} < (IDW+1)'(ENTRIES));
    assign upd_acc     = upd_vld  && upd_in_rng  && entry_vld[upd_id];
    assign free_acc    = free_vld && free_in_rng && entry_vld[free_id];
    assign upd_bad     = upd_vld  && !upd_acc;
    assign free_bad    = free_vld && !free_acc;

    assign alloc_oh = alloc_acc ? (ENTRIES'(1) << alloc_id) : '0;
    assign upd_oh   = upd_acc   ? (ENTRIES'(1) << upd_id)   : '0;
    assign free_oh  = free_acc  ? (ENTRIES'(1) << free_id)  : '0;

    assign rr_nxt = ({1'b0, alloc_id} == (IDW+1)'(ENTRIES-1)) ? '0 : alloc_id + 1'b1;

    // Registered state: bitmap, occupancy, round-robin pointer, enable pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_vld <= '0;
            ff_en_e1  <= '0;
            count     <= '0;
            rr_ptr    <= '0;
            err       <= 1'b0;
        end else begin
            entry_vld <= (entry_vld | alloc_oh) & ~free_oh;
            ff_en_e1  <= alloc_oh | upd_oh;
            count     <= count + {{IDW{1'b0}}, alloc_acc} - {{IDW{1'b0}}, free_acc};
            if (alloc_acc)
                rr_ptr <= rr_nxt;
            if (upd_bad || free_bad)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_entry_alloc_ctrl.sv
module tb_entry_alloc_ctrl;

    localparam int E = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         alloc_vld = 1'b0;
    logic         alloc_rdy;
    logic [W-1:0] alloc_id;
    logic         upd_vld = 1'b0;
    logic [W-1:0] upd_id = '0;
    logic         free_vld = 1'b0;
    logic [W-1:0] free_id = '0;
    logic [E-1:0] ff_en_e1;
    logic [E-1:0] entry_vld;
    logic [W:0]   count;
    logic         full;
    logic         empty;
    logic         err;

    always #5 clk = ~clk;

    entry_alloc_ctrl #(.ENTRIES(E), .IDW(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_vld (alloc_vld),
        .alloc_rdy (alloc_rdy),
        .alloc_id  (alloc_id),
        .upd_vld   (upd_vld),
        .upd_id    (upd_id),
        .free_vld  (free_vld),
        .free_id   (free_id),
        .ff_en_e1  (ff_en_e1),
        .entry_vld (entry_vld),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a set of occupied slots, a pointer, and a flag.
    bit           m_vld [E];
    int           m_rr;
    bit           m_err;
    logic [E-1:0] m_ffen;

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < E; i++) n += m_vld[i] ? 1 : 0;
        return n;
    endfunction

    function automatic int m_find();
        for (int k = 0; k < E; k++)
            if (!m_vld[(m_rr + k) % E]) return (m_rr + k) % E;
        return 0;
    endfunction

    int a_id;
    bit a_ok, u_ok, f_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < E; i++) m_vld[i] = 1'b0;
            m_rr   = 0;
            m_err  = 1'b0;
            m_ffen = '0;
        end else begin
            a_id = m_find();
            a_ok = alloc_vld && (m_cnt() < E);
            u_ok = upd_vld  && (int'(upd_id)  < E) && m_vld[upd_id];
            f_ok = free_vld && (int'(free_id) < E) && m_vld[free_id];
            if ((upd_vld && !u_ok) || (free_vld && !f_ok)) m_err = 1'b1;
            m_ffen = '0;
            if (a_ok) m_ffen[a_id] = 1'b1;
            if (u_ok) m_ffen[upd_id] = 1'b1;
            if (f_ok) m_vld[free_id] = 1'b0;
            if (a_ok) begin
                m_vld[a_id] = 1'b1;
                m_rr = (a_id + 1) % E;
            end
        end
    end

    logic [E-1:0] m_bits;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < E; i++) m_bits[i] = m_vld[i];
            chk("model entry_vld", 32'(entry_vld), 32'(m_bits));
            chk("model count",     32'(count),     32'(m_cnt()));
            chk("model ff_en_e1",  32'(ff_en_e1),  32'(m_ffen));
            chk("model err",       32'(err),       32'(m_err));
            chk("model full",      32'(full),      32'(m_cnt() == E));
            chk("model empty",     32'(empty),     32'(m_cnt() == 0));
            chk("model alloc_rdy", 32'(alloc_rdy), 32'(m_cnt() != E));
            if (m_cnt() != E)
                chk("model alloc_id", 32'(alloc_id), 32'(m_find()));
        end
    end

    task automatic drive(input bit a, input bit u, input int uid, input bit f, input int fid);
        alloc_vld = a;
        upd_vld   = u;
        upd_id    = W'(uid);
        free_vld  = f;
        free_id   = W'(fid);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " entry_vld"}, 32'(entry_vld), 32'h0);
        chk({tag, " ff_en_e1"},  32'(ff_en_e1),  32'h0);
        chk({tag, " count"},     32'(count),     32'h0);
        chk({tag, " err"},       32'(err),       32'h0);
        chk({tag, " empty"},     32'(empty),     32'h1);
        chk({tag, " full"},      32'(full),      32'h0);
        chk({tag, " alloc_rdy"}, 32'(alloc_rdy), 32'h1);
        chk({tag, " alloc_id"},  32'(alloc_id),  32'h0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill from empty: ids 0..7 in order, pulse one cycle behind
        for (int i = 0; i < E; i++) begin
            if (i > 0) @(negedge clk);
            drive(1, 0, 0, 0, 0);
            #1;
            chk("fill alloc_id", 32'(alloc_id), 32'(i));
            chk("fill count",    32'(count),    32'(i));
            if (i > 0) chk("fill ff_en_e1", 32'(ff_en_e1), 32'(1) << (i - 1));
        end
        @(negedge clk); drive(1, 0, 0, 0, 0); #1;
        chk("full ff_en_e1",  32'(ff_en_e1),  32'h80);
        chk("full flag",      32'(full),      32'h1);
        chk("full alloc_rdy", 32'(alloc_rdy), 32'h0);
        chk("full count",     32'(count),     32'h8);
        @(negedge clk); drive(0, 0, 0, 1, 3); #1;
        chk("full ignore ff",  32'(ff_en_e1),  32'h0);
        chk("full ignore err", 32'(err),       32'h0);
        chk("full ignore vld", 32'(entry_vld), 32'hFF);
        @(negedge clk); drive(1, 0, 0, 0, 0); #1;
        chk("free3 vld",      32'(entry_vld), 32'hF7);
        chk("free3 count",    32'(count),     32'h7);
        chk("refill alloc_id", 32'(alloc_id), 32'h3);
        @(negedge clk); drive(0, 0, 0, 1, 4); #1;
        chk("refill vld",   32'(entry_vld), 32'hFF);
        chk("refill count", 32'(count),     32'h8);
        chk("refill ff",    32'(ff_en_e1),  32'h08);

        // Move rr_ptr to 5, then free 0 and 2 and check the wrap to 0
        @(negedge clk); drive(1, 0, 0, 0, 0); #1;
        chk("rr4 alloc_id", 32'(alloc_id), 32'h4);
        @(negedge clk); drive(0, 0, 0, 1, 0); #1;
        chk("rr5 ff", 32'(ff_en_e1), 32'h10);
        @(negedge clk); drive(0, 0, 0, 1, 2);
        @(negedge clk); drive(1, 0, 0, 0, 0); #1;
        chk("wrap vld",      32'(entry_vld), 32'hFA);
        chk("wrap alloc_id", 32'(alloc_id),  32'h0);
        @(negedge clk); drive(1, 0, 0, 0, 0); #1;
        chk("after wrap ff",  32'(ff_en_e1), 32'h01);
        chk("rr1 alloc_id",   32'(alloc_id), 32'h2);
        @(negedge clk); drive(0, 0, 0, 1, 4);

        // Simultaneous alloc (id 4) and free of entry 1
        @(negedge clk); drive(1, 0, 0, 1, 1); #1;
        chk("alloc+free alloc_id", 32'(alloc_id), 32'h4);
        chk("alloc+free pre cnt",  32'(count),    32'h7);
        @(negedge clk); drive(0, 0, 0, 1, 6); #1;
        chk("alloc+free count", 32'(count),     32'h7);
        chk("alloc+free vld",   32'(entry_vld), 32'hFD);
        chk("alloc+free ff",    32'(ff_en_e1),  32'h10);

        // Update to an invalid entry, then to a valid one
        @(negedge clk); drive(0, 1, 6, 0, 0); #1;
        chk("free6 vld", 32'(entry_vld), 32'hBD);
        @(negedge clk); drive(0, 1, 2, 0, 0); #1;
        chk("bad upd ff",  32'(ff_en_e1), 32'h0);
        chk("bad upd err", 32'(err),      32'h1);
        @(negedge clk); drive(0, 1, 3, 1, 3); #1;
        chk("upd2 ff",  32'(ff_en_e1), 32'h04);
        chk("upd2 err", 32'(err),      32'h1);
        @(negedge clk); drive(0, 1, 0, 0, 0); #1;
        chk("upd+free ff",  32'(ff_en_e1),  32'h08);
        chk("upd+free vld", 32'(entry_vld), 32'hB5);
        chk("five count",   32'(count),     32'h5);

        // Asynchronous reset between edges with a pulse pending
        @(posedge clk); #2;
        drive(0, 0, 0, 0, 0);
        chk("pre-reset ff",  32'(ff_en_e1), 32'h01);
        chk("pre-reset err", 32'(err),      32'h1);
        rst_n = 1'b0;
        #1 chk_reset_vals("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0); #1;
        chk("post-reset alloc_id", 32'(alloc_id), 32'h0);
        @(negedge clk); drive(0, 0, 0, 0, 0); #1;
        chk("post-reset vld", 32'(entry_vld), 32'h01);

        // Randomized traffic, occasionally hit with an async reset
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            drive(($urandom % 3) != 0, ($urandom % 3) == 0, $urandom % E,
                  ($urandom % 5) < 2, $urandom % E);
            if ($urandom % 400 == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk); drive(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
